// File: rtl/awgn_channel_mc.sv
`default_nettype none
// ============================================================================
// Module   : awgn_channel_mc
// Purpose  : Multi-lane AWGN channel model. Aligns TX with external noise, then
//            applies a frame-aligned mode and saturates. Keeps channel statistics.
// Revision : 1.0 - initial release
// ============================================================================
module awgn_channel_mc #(
    parameter int DATA_W    = 12,
    parameter int N_CH      = 2,
    parameter int NOISE_LAT = 3,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [N_CH*DATA_W-1:0]   tx_i,
    input  logic [N_CH*DATA_W-1:0]   tx_q,
    input  logic                     tx_valid,
    input  logic                     tx_sof,
    input  logic [N_CH*DATA_W-1:0]   noise_i,
    input  logic [N_CH*DATA_W-1:0]   noise_q,
    input  logic                     noise_valid,
    input  logic                     cfg_wr,
    input  logic [1:0]               cfg_mode,
    input  logic [DATA_W-1:0]        cfg_dc_i,
    input  logic [DATA_W-1:0]        cfg_dc_q,
    input  logic                     stat_clr,
    output logic [N_CH*DATA_W-1:0]   rx_i,
    output logic [N_CH*DATA_W-1:0]   rx_q,
    output logic                     rx_valid,
    output logic                     rx_sof,
    output logic [N_CH*CNT_W-1:0]    sat_cnt,
    output logic [CNT_W-1:0]         smp_cnt,
    output logic                     misalign,
    output logic                     cfg_pending
);

    localparam int         c_bus_w       = N_CH * DATA_W;
    localparam logic [1:0] c_mode_bypass = 2'b00;
    localparam logic [1:0] c_mode_add    = 2'b01;
    localparam logic [1:0] c_mode_add_dc = 2'b10;
    localparam logic [1:0] c_mode_noise  = 2'b11;
    localparam logic signed [DATA_W+1:0] c_sat_max = {3'b000, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W+1:0] c_sat_min = {3'b111, {(DATA_W-1){1'b0}}};

    // Returns {clipped, saturated result} for one branch of one lane.
    function automatic logic [DATA_W:0] f_chan(
        input logic [DATA_W-1:0] tx,
        input logic [DATA_W-1:0] n,
        input logic [DATA_W-1:0] dc,
        input logic [1:0]        mode
    );
        logic signed [DATA_W+1:0] a;
        logic signed [DATA_W+1:0] b;
        logic signed [DATA_W+1:0] c;
        logic signed [DATA_W+1:0] s;
        a = (mode == c_mode_noise)  ? '0 : $signed({{2{tx[DATA_W-1]}}, tx});
        b = (mode == c_mode_bypass) ? '0 : $signed({{2{n[DATA_W-1]}}, n});
        c = (mode == c_mode_add_dc) ? $signed({{2{dc[DATA_W-1]}}, dc}) : '0;
        s = a + b + c;
        if (s > c_sat_max)
            return {1'b1, c_sat_max[DATA_W-1:0]};
        else if (s < c_sat_min)
            return {1'b1, c_sat_min[DATA_W-1:0]};
        else
            return {1'b0, s[DATA_W-1:0]};
    endfunction

    logic [1:0]        r_act_mode, r_sh_mode, w_eff_mode;
    logic [DATA_W-1:0] r_act_dc_i, r_act_dc_q, r_sh_dc_i, r_sh_dc_q;
    logic [DATA_W-1:0] w_eff_dc_i, w_eff_dc_q;
    logic              r_pending;
    logic              w_sof_beat;

    assign w_sof_beat = tx_valid & tx_sof;

    // The sof beat itself must already see the config it switches in.
    always_comb begin
        w_eff_mode = r_act_mode;
        w_eff_dc_i = r_act_dc_i;
        w_eff_dc_q = r_act_dc_q;
        if (w_sof_beat && cfg_wr) begin
            w_eff_mode = cfg_mode;
            w_eff_dc_i = cfg_dc_i;
            w_eff_dc_q = cfg_dc_q;
        end else if (w_sof_beat && r_pending) begin
            w_eff_mode = r_sh_mode;
            w_eff_dc_i = r_sh_dc_i;
            w_eff_dc_q = r_sh_dc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_mode <= c_mode_add;
            r_act_dc_i <= '0;
            r_act_dc_q <= '0;
            r_sh_mode  <= c_mode_add;
            r_sh_dc_i  <= '0;
            r_sh_dc_q  <= '0;
            r_pending  <= 1'b0;
        end else if (en) begin
            r_act_mode <= w_eff_mode;
            r_act_dc_i <= w_eff_dc_i;
            r_act_dc_q <= w_eff_dc_q;
            if (cfg_wr) begin
                r_sh_mode <= cfg_mode;
                r_sh_dc_i <= cfg_dc_i;
                r_sh_dc_q <= cfg_dc_q;
            end
            r_pending <= w_sof_beat ? 1'b0 : (r_pending | cfg_wr);
        end
    end

    logic [c_bus_w-1:0] r_dl_ti   [NOISE_LAT];
    logic [c_bus_w-1:0] r_dl_tq   [NOISE_LAT];
    logic               r_dl_v    [NOISE_LAT];
    logic               r_dl_sof  [NOISE_LAT];
    logic [1:0]         r_dl_mode [NOISE_LAT];
    logic [DATA_W-1:0]  r_dl_dci  [NOISE_LAT];
    logic [DATA_W-1:0]  r_dl_dcq  [NOISE_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NOISE_LAT; k++) begin
                r_dl_ti[k]   <= '0;
                r_dl_tq[k]   <= '0;
                r_dl_v[k]    <= 1'b0;
                r_dl_sof[k]  <= 1'b0;
                r_dl_mode[k] <= '0;
                r_dl_dci[k]  <= '0;
                r_dl_dcq[k]  <= '0;
            end
        end else if (en) begin
            r_dl_ti[0]   <= tx_i;
            r_dl_tq[0]   <= tx_q;
            r_dl_v[0]    <= tx_valid;
            r_dl_sof[0]  <= w_sof_beat;
            r_dl_mode[0] <= w_eff_mode;
            r_dl_dci[0]  <= w_eff_dc_i;
            r_dl_dcq[0]  <= w_eff_dc_q;
            for (int k = 1; k < NOISE_LAT; k++) begin
                r_dl_ti[k]   <= r_dl_ti[k-1];
                r_dl_tq[k]   <= r_dl_tq[k-1];
                r_dl_v[k]    <= r_dl_v[k-1];
                r_dl_sof[k]  <= r_dl_sof[k-1];
                r_dl_mode[k] <= r_dl_mode[k-1];
                r_dl_dci[k]  <= r_dl_dci[k-1];
                r_dl_dcq[k]  <= r_dl_dcq[k-1];
            end
        end
    end

    logic [1:0] w_tail_mode;
    logic       w_tail_ok;
    logic       w_misalign_set;

    assign w_tail_mode    = r_dl_mode[NOISE_LAT-1];
    assign w_tail_ok      = r_dl_v[NOISE_LAT-1] &
                            (noise_valid | (w_tail_mode == c_mode_bypass));
    assign w_misalign_set = (w_tail_mode != c_mode_bypass) &
                            (r_dl_v[NOISE_LAT-1] != noise_valid);

    logic [c_bus_w-1:0] w_sum_i, w_sum_q;
    logic [c_bus_w-1:0] r_rx_i, r_rx_q;
    logic               r_rx_valid, r_rx_sof;

    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        logic [DATA_W:0]  w_res_i;
        logic [DATA_W:0]  w_res_q;
        logic [CNT_W-1:0] r_sat;

        assign w_res_i = f_chan(r_dl_ti[NOISE_LAT-1][g*DATA_W +: DATA_W],
                                noise_i[g*DATA_W +: DATA_W],
                                r_dl_dci[NOISE_LAT-1], w_tail_mode);
        assign w_res_q = f_chan(r_dl_tq[NOISE_LAT-1][g*DATA_W +: DATA_W],
                                noise_q[g*DATA_W +: DATA_W],
                                r_dl_dcq[NOISE_LAT-1], w_tail_mode);
        assign w_sum_i[g*DATA_W +: DATA_W] = w_res_i[DATA_W-1:0];
        assign w_sum_q[g*DATA_W +: DATA_W] = w_res_q[DATA_W-1:0];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_sat <= '0;
            else if (en) begin
                if (stat_clr)
                    r_sat <= '0;
                else if (w_tail_ok && (w_res_i[DATA_W] || w_res_q[DATA_W]) && (r_sat != '1))
                    r_sat <= r_sat + CNT_W'(1);
            end
        end

        assign sat_cnt[g*CNT_W +: CNT_W] = r_sat;
    end

    logic [CNT_W-1:0] r_smp;
    logic             r_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_i     <= '0;
            r_rx_q     <= '0;
            r_rx_valid <= 1'b0;
            r_rx_sof   <= 1'b0;
            r_smp      <= '0;
            r_misalign <= 1'b0;
        end else if (en) begin
            r_rx_valid <= w_tail_ok;
            r_rx_sof   <= r_dl_sof[NOISE_LAT-1] & w_tail_ok;
            if (w_tail_ok) begin
                r_rx_i <= w_sum_i;
                r_rx_q <= w_sum_q;
            end
            if (stat_clr) begin
                r_smp      <= '0;
                r_misalign <= 1'b0;
            end else begin
                if (w_tail_ok && (r_smp != '1))
                    r_smp <= r_smp + CNT_W'(1);
                if (w_misalign_set)
                    r_misalign <= 1'b1;
            end
        end
    end

    assign rx_i        = r_rx_i;
    assign rx_q        = r_rx_q;
    assign rx_valid    = r_rx_valid;
    assign rx_sof      = r_rx_sof;
    assign smp_cnt     = r_smp;
    assign misalign    = r_misalign;
    assign cfg_pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_awgn_channel_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_awgn_channel_mc
// Purpose  : Directed self-checking bench for awgn_channel_mc (12-bit, 2 lanes,
//            noise latency 3, 4-bit counters so the counter ceiling is reachable).
// Revision : 1.0 - initial release
// ============================================================================
module tb_awgn_channel_mc;

    localparam int DATA_W    = 12;
    localparam int N_CH      = 2;
    localparam int NOISE_LAT = 3;
    localparam int CNT_W     = 4;
    localparam int BW        = N_CH * DATA_W;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [BW-1:0]   tx_i, tx_q, noise_i, noise_q;
    logic            tx_valid, tx_sof, noise_valid;
    logic            cfg_wr;
    logic [1:0]      cfg_mode;
    logic [DATA_W-1:0] cfg_dc_i, cfg_dc_q;
    logic            stat_clr;
    logic [BW-1:0]   rx_i, rx_q;
    logic            rx_valid, rx_sof;
    logic [N_CH*CNT_W-1:0] sat_cnt;
    logic [CNT_W-1:0] smp_cnt;
    logic            misalign, cfg_pending;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Noise generator model: each beat's noise is scheduled NOISE_LAT (+late) cycles ahead.
    logic          sv [16];
    logic [BW-1:0] si [16];
    logic [BW-1:0] sq [16];

    always #5 clk = ~clk;

    awgn_channel_mc #(
        .DATA_W(DATA_W), .N_CH(N_CH), .NOISE_LAT(NOISE_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .tx_i(tx_i), .tx_q(tx_q), .tx_valid(tx_valid), .tx_sof(tx_sof),
        .noise_i(noise_i), .noise_q(noise_q), .noise_valid(noise_valid),
        .cfg_wr(cfg_wr), .cfg_mode(cfg_mode), .cfg_dc_i(cfg_dc_i), .cfg_dc_q(cfg_dc_q),
        .stat_clr(stat_clr),
        .rx_i(rx_i), .rx_q(rx_q), .rx_valid(rx_valid), .rx_sof(rx_sof),
        .sat_cnt(sat_cnt), .smp_cnt(smp_cnt), .misalign(misalign),
        .cfg_pending(cfg_pending)
    );

    function automatic logic [BW-1:0] pk(input int l1, input int l0);
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        a = DATA_W'(l1);
        b = DATA_W'(l0);
        return {a, b};
    endfunction

    task automatic clear_sched();
        for (int k = 0; k < 16; k++) begin
            sv[k] = 1'b0;
            si[k] = '0;
            sq[k] = '0;
        end
    endtask

    task automatic drive(input logic v, input logic sof, input logic [BW-1:0] ti,
                         input logic [BW-1:0] tq, input logic nv, input logic [BW-1:0] ni,
                         input logic [BW-1:0] nq, input int late);
        int slot;
        tx_valid = v;
        tx_sof   = sof;
        tx_i     = ti;
        tx_q     = tq;
        if (nv) begin
            slot     = (cyc + NOISE_LAT + late) % 16;
            sv[slot] = 1'b1;
            si[slot] = ni;
            sq[slot] = nq;
        end
        slot        = cyc % 16;
        noise_valid = sv[slot];
        noise_i     = sv[slot] ? si[slot] : 24'h5A5_3C3;
        noise_q     = sv[slot] ? sq[slot] : 24'h1F0_0E1;
        sv[slot]    = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 0);
    endtask

    task automatic do_stat_clr();
        stat_clr = 1'b1;
        idle();
        stat_clr = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        n_cmp++; if (rx_i !== '0 || rx_q !== '0) begin n_fail++; $display("FAIL reset_rx_data: got %h/%h want 0/0", rx_i, rx_q); end
        n_cmp++; if (smp_cnt !== '0 || sat_cnt !== '0) begin n_fail++; $display("FAIL reset_counters: got smp %h sat %h want 0", smp_cnt, sat_cnt); end
        n_cmp++; if (misalign !== 1'b0 || cfg_pending !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got misalign %b pending %b want 0 0", misalign, cfg_pending); end
    endtask

    task automatic test_latency_add();
        drive(1'b1, 1'b1, pk(-7, 100), '0, 1'b1, pk(7, 50), '0, 0);
        idle();
        idle();
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early_valid: got %b want 0", rx_valid); end
        idle();
        n_cmp++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid: got %b want 1", rx_valid); end
        n_cmp++; if (rx_i !== pk(0, 150)) begin n_fail++; $display("FAIL latency_rx_i: got %h want %h", rx_i, pk(0, 150)); end
        n_cmp++; if (rx_q !== '0 || rx_sof !== 1'b1) begin n_fail++; $display("FAIL latency_q_sof: got %h sof %b want 0 sof 1", rx_q, rx_sof); end
        n_cmp++; if (smp_cnt !== 4'd1) begin n_fail++; $display("FAIL latency_smp_cnt: got %0d want 1", smp_cnt); end
        idle();
        n_cmp++; if (rx_valid !== 1'b0 || rx_i !== pk(0, 150)) begin n_fail++; $display("FAIL latency_hold: got valid %b rx_i %h want 0 %h", rx_valid, rx_i, pk(0, 150)); end
    endtask

    task automatic test_saturation();
        do_stat_clr();
        drive(1'b1, 1'b0, pk(0, 2000),  '0, 1'b1, pk(0, 100),  '0, 0);
        drive(1'b1, 1'b0, pk(0, -2000), '0, 1'b1, pk(0, -100), '0, 0);
        drive(1'b1, 1'b0, pk(0, 2000),  '0, 1'b1, pk(0, 47),   '0, 0);
        idle();
        n_cmp++; if (rx_i !== pk(0, 2047)) begin n_fail++; $display("FAIL sat_pos: got %h want %h", rx_i, pk(0, 2047)); end
        idle();
        n_cmp++; if (rx_i !== pk(0, -2048) || rx_valid !== 1'b1) begin n_fail++; $display("FAIL sat_neg: got %h v %b want %h v 1", rx_i, rx_valid, pk(0, -2048)); end
        idle();
        n_cmp++; if (rx_i !== pk(0, 2047)) begin n_fail++; $display("FAIL sat_exact: got %h want %h", rx_i, pk(0, 2047)); end
        n_cmp++; if (sat_cnt !== {4'd0, 4'd2}) begin n_fail++; $display("FAIL sat_cnt: got %h want 02", sat_cnt); end
        n_cmp++; if (smp_cnt !== 4'd3) begin n_fail++; $display("FAIL sat_smp_cnt: got %0d want 3", smp_cnt); end
    endtask

    task automatic test_frame_cfg();
        drive(1'b1, 1'b1, '0, '0, 1'b1, pk(0, 10), '0, 0);
        cfg_wr = 1'b1; cfg_mode = 2'b10; cfg_dc_i = DATA_W'(-30); cfg_dc_q = '0;
        drive(1'b1, 1'b0, '0, '0, 1'b1, pk(0, 10), '0, 0);
        cfg_wr = 1'b0;
        n_cmp++; if (cfg_pending !== 1'b1) begin n_fail++; $display("FAIL cfg_pending_set: got %b want 1", cfg_pending); end
        drive(1'b1, 1'b0, '0, '0, 1'b1, pk(0, 10), '0, 0);
        drive(1'b1, 1'b1, '0, '0, 1'b1, pk(0, 10), '0, 0);
        n_cmp++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL cfg_pending_clr: got %b want 0", cfg_pending); end
        n_cmp++; if (rx_i !== pk(0, 10) || rx_sof !== 1'b1) begin n_fail++; $display("FAIL cfg_f0: got %h sof %b want %h sof 1", rx_i, rx_sof, pk(0, 10)); end
        idle();
        idle();
        n_cmp++; if (rx_i !== pk(0, 10) || rx_sof !== 1'b0) begin n_fail++; $display("FAIL cfg_midframe: got %h sof %b want %h sof 0", rx_i, rx_sof, pk(0, 10)); end
        idle();
        n_cmp++; if (rx_i !== pk(-30, -20) || rx_q !== '0 || rx_sof !== 1'b1) begin n_fail++; $display("FAIL cfg_newframe: got %h/%h sof %b want %h/0 sof 1", rx_i, rx_q, rx_sof, pk(-30, -20)); end
        cfg_wr = 1'b1; cfg_mode = 2'b01; cfg_dc_i = '0;
        drive(1'b1, 1'b1, '0, '0, 1'b1, pk(0, 10), '0, 0);
        cfg_wr = 1'b0;
        n_cmp++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL cfg_coincide_pending: got %b want 0", cfg_pending); end
        idle(); idle(); idle();
        n_cmp++; if (rx_i !== pk(0, 10) || rx_sof !== 1'b1) begin n_fail++; $display("FAIL cfg_coincide: got %h sof %b want %h sof 1", rx_i, rx_sof, pk(0, 10)); end
    endtask

    task automatic test_bypass_noise_only();
        cfg_wr = 1'b1; cfg_mode = 2'b00;
        idle();
        cfg_wr = 1'b0;
        drive(1'b1, 1'b1, pk(-1, 123), pk(-456, 7), 1'b0, '0, '0, 0);
        drive(1'b1, 1'b0, pk(2047, -2048), pk(1, 2), 1'b0, '0, '0, 0);
        idle(); idle();
        n_cmp++; if (rx_valid !== 1'b1 || rx_i !== pk(-1, 123) || rx_q !== pk(-456, 7)) begin n_fail++; $display("FAIL bypass_b0: got v %b %h/%h want 1 %h/%h", rx_valid, rx_i, rx_q, pk(-1, 123), pk(-456, 7)); end
        idle();
        n_cmp++; if (rx_valid !== 1'b1 || rx_i !== pk(2047, -2048) || rx_q !== pk(1, 2)) begin n_fail++; $display("FAIL bypass_b1: got v %b %h/%h want 1 %h/%h", rx_valid, rx_i, rx_q, pk(2047, -2048), pk(1, 2)); end
        n_cmp++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL bypass_misalign: got %b want 0", misalign); end
        cfg_wr = 1'b1; cfg_mode = 2'b11;
        idle();
        cfg_wr = 1'b0;
        drive(1'b1, 1'b1, pk(0, 500), '0, 1'b1, pk(9, -3), '0, 0);
        idle(); idle(); idle();
        n_cmp++; if (rx_valid !== 1'b1 || rx_i !== pk(9, -3) || rx_q !== '0) begin n_fail++; $display("FAIL noise_only: got v %b %h/%h want 1 %h/0", rx_valid, rx_i, rx_q, pk(9, -3)); end
    endtask

    task automatic test_misalign();
        do_stat_clr();
        cfg_wr = 1'b1; cfg_mode = 2'b01;
        drive(1'b1, 1'b1, pk(0, 1), '0, 1'b1, pk(0, 2), '0, 0);
        cfg_wr = 1'b0;
        drive(1'b1, 1'b0, pk(0, 5), '0, 1'b1, pk(0, 5), '0, 1);
        idle();
        drive(1'b1, 1'b0, pk(0, 20), '0, 1'b1, pk(0, 1), '0, 0);
        n_cmp++; if (rx_valid !== 1'b1 || rx_i !== pk(0, 3) || misalign !== 1'b0) begin n_fail++; $display("FAIL mis_good: got v %b %h mis %b want 1 %h 0", rx_valid, rx_i, misalign, pk(0, 3)); end
        idle();
        n_cmp++; if (rx_valid !== 1'b0 || misalign !== 1'b1) begin n_fail++; $display("FAIL mis_late: got v %b mis %b want 0 1", rx_valid, misalign); end
        idle();
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL mis_orphan_noise: got v %b want 0", rx_valid); end
        idle();
        n_cmp++; if (rx_valid !== 1'b1 || rx_i !== pk(0, 21) || misalign !== 1'b1) begin n_fail++; $display("FAIL mis_sticky: got v %b %h mis %b want 1 %h 1", rx_valid, rx_i, misalign, pk(0, 21)); end
        do_stat_clr();
        n_cmp++; if (misalign !== 1'b0 || smp_cnt !== '0) begin n_fail++; $display("FAIL mis_clear: got mis %b smp %0d want 0 0", misalign, smp_cnt); end
    endtask

    task automatic test_cnt_limit();
        do_stat_clr();
        for (int k = 0; k < 20; k++)
            drive(1'b1, 1'b0, pk(0, 2000), '0, 1'b1, pk(0, 100), '0, 0);
        idle(); idle(); idle();
        n_cmp++; if (sat_cnt !== {4'd0, 4'd15}) begin n_fail++; $display("FAIL cnt_sat_limit: got %h want 0f", sat_cnt); end
        n_cmp++; if (smp_cnt !== 4'd15) begin n_fail++; $display("FAIL cnt_smp_limit: got %0d want 15", smp_cnt); end
        drive(1'b1, 1'b0, pk(0, 2000), '0, 1'b1, pk(0, 100), '0, 0);
        idle(); idle();
        do_stat_clr();
        n_cmp++; if (rx_valid !== 1'b1 || smp_cnt !== '0 || sat_cnt !== '0) begin n_fail++; $display("FAIL cnt_clr_wins: got v %b smp %0d sat %h want 1 0 00", rx_valid, smp_cnt, sat_cnt); end
    endtask

    task automatic test_reset_midframe();
        cfg_wr = 1'b1; cfg_mode = 2'b10; cfg_dc_i = 12'd7;
        idle();
        cfg_wr = 1'b0; cfg_dc_i = '0;
        drive(1'b1, 1'b1, pk(0, 2000), '0, 1'b1, pk(0, 100), '0, 0);
        drive(1'b1, 1'b0, pk(0, 2000), '0, 1'b1, pk(0, 100), '0, 0);
        #2;
        rst_n = 1'b0;
        tx_valid = 1'b0; tx_sof = 1'b0; noise_valid = 1'b0;
        #1;
        n_cmp++; if (rx_i !== '0 || rx_q !== '0 || rx_valid !== 1'b0 || rx_sof !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rx: got %h/%h v %b sof %b want all 0", rx_i, rx_q, rx_valid, rx_sof); end
        n_cmp++; if (sat_cnt !== '0 || smp_cnt !== '0 || misalign !== 1'b0 || cfg_pending !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stat: got sat %h smp %0d mis %b pend %b want 0", sat_cnt, smp_cnt, misalign, cfg_pending); end
        clear_sched();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            idle();
            n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stale_valid: got %b want 0 at step %0d", rx_valid, k); end
        end
        drive(1'b1, 1'b1, pk(0, 4), '0, 1'b1, pk(0, 5), '0, 0);
        idle(); idle(); idle();
        n_cmp++; if (rx_valid !== 1'b1 || rx_i !== pk(0, 9) || misalign !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_default: got v %b %h mis %b want 1 %h 0", rx_valid, rx_i, misalign, pk(0, 9)); end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1;
        tx_i = '0; tx_q = '0; tx_valid = 1'b0; tx_sof = 1'b0;
        noise_i = '0; noise_q = '0; noise_valid = 1'b0;
        cfg_wr = 1'b0; cfg_mode = 2'b01; cfg_dc_i = '0; cfg_dc_q = '0;
        stat_clr = 1'b0;
        clear_sched();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_latency_add();
        test_saturation();
        test_frame_cfg();
        test_bypass_noise_only();
        test_misalign();
        test_cnt_limit();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/awgn_channel_mc.md
# awgn_channel_mc

Multi-lane, parametrised AWGN channel model for in-FPGA BER sweeps. It sits between the transmitter and the receiver or HDMI path. For each of N_CH complex lanes it aligns clean TX samples with externally generated noise (from an awgn_generator bank), then applies a per-frame selectable mode: bypass, add, add plus DC offset, or noise-only. Results are saturated to DATA_W, and the block keeps saturation and sample statistics plus a sticky noise/TX misalignment flag.

## Interface
Parameters:
- DATA_W, 12: sample width, signed two's complement (Q1.(DATA_W-1)).
- N_CH, 2: number of complex lanes. Lane k occupies bits [k*DATA_W +: DATA_W] of each packed bus.
- NOISE_LAT, 3: noise arrival delay in cycles relative to its TX sample. Range 1..8.
- CNT_W, 16: width of each statistics counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  global enable. When low, every register holds, including counters.
- tx_i, tx_q  in  N_CH*DATA_W  clean samples.
- tx_valid  in  1  TX sample strobe, shared by all lanes.
- tx_sof  in  1  start of frame. Meaningful only with tx_valid.
- noise_i, noise_q  in  N_CH*DATA_W  noise samples.
- noise_valid  in  1  noise strobe. Nominally equals tx_valid delayed by NOISE_LAT.
- cfg_wr  in  1  one-cycle strobe that loads the shadow config.
- cfg_mode  in  2  00 BYPASS, 01 ADD, 10 ADD_DC, 11 NOISE_ONLY.
- cfg_dc_i, cfg_dc_q  in  DATA_W  signed DC offset, common to all lanes.
- stat_clr  in  1  synchronous clear of counters and the misalign flag.
- rx_i, rx_q  out  N_CH*DATA_W  channel output.
- rx_valid  out  1  output strobe.
- rx_sof  out  1  start of frame, aligned with rx_valid.
- sat_cnt  out  N_CH*CNT_W  per-lane count of saturated output samples.
- smp_cnt  out  CNT_W  count of output samples (rx_valid beats).
- misalign  out  1  sticky alignment error.
- cfg_pending  out  1  shadow config is loaded but not yet active.

## Operation
- Config path
  - cfg_wr copies cfg_mode and the DC values into the shadow registers and sets cfg_pending.
  - On an input beat with tx_valid && tx_sof && cfg_pending, shadow copies to active and cfg_pending clears.
  - If cfg_wr coincides with that beat, the new cfg_wr values go straight to active and cfg_pending stays 0.
  - A cfg_wr issued mid-frame therefore never affects the current frame.
- Tagging: each input beat captures {tx_i, tx_q, tx_valid, tx_sof, active mode, active DC} into a NOISE_LAT-deep delay line. Config travels with its sample.
- Add stage, using the tail of the delay line and the current noise inputs, per lane and per branch:
  - BYPASS: s = tx.
  - ADD: s = tx + n.
  - ADD_DC: s = tx + n + dc.
  - NOISE_ONLY: s = n.
  - Compute s at DATA_W+2 bits with sign extension, then saturate: s > 2^(DATA_W-1)-1 → max; s < -2^(DATA_W-1) → min; otherwise truncate.
- Beat validity at the tail:
  - tail_ok = tail_valid && (noise_valid || tail_mode==BYPASS).
  - If tail_mode != BYPASS and tail_valid != noise_valid, set misalign. It remains set until stat_clr or reset.
- Statistics, updated on each output beat:
  - smp_cnt increments.
  - sat_cnt[k] increments when either the I or Q branch of lane k clipped.
  - Counters stop at 2^CNT_W-1 and do not wrap.
  - stat_clr wins over a simultaneous increment or misalign set; the result is 0.

## Timing
- Latency: a sample entering with tx_valid at cycle t appears at rx_* with rx_valid at cycle t+NOISE_LAT+1. Throughput is one beat per cycle.
- rx_sof = tail_sof && tail_ok, registered with the data.
- Rx outputs are registered and held between beats. rx_valid is high only for tail_ok beats.
- en low freezes the pipeline. Cycle counts refer to en-high cycles.
- Reset, including mid-frame:
  - All outputs go to 0.
  - The delay line is cleared, so in-flight samples are dropped.
  - Active and shadow config reset to ADD with DC=0; cfg_pending=0.
  - The first valid output appears at least NOISE_LAT+1 cycles after reset is released.
- stat_clr and cfg_wr take effect on the next clock edge.

## Test plan
- **Latency/ADD** (DATA_W=12, N_CH=2, NOISE_LAT=3): lane0 tx_i=100 at cycle 0, noise_i=50 at cycle 3 → rx_i lane0=150 with rx_valid at cycle 4. Lane1 tx_i=-7, noise_i=7 → 0. smp_cnt=1.
- **Saturation**: tx=2000, n=100 → 2047; tx=-2000, n=-100 → -2048; tx=2000, n=47 → 2047 with no clip → sat_cnt lane0=2.
- **Frame-aligned config**: cfg_wr mode=ADD_DC, dc_i=-30 mid-frame → cfg_pending=1 and remaining beats still use ADD. At the next tx_sof, tx=0, n=10 → rx=-20, rx_sof=1, cfg_pending=0. Repeat with cfg_wr coinciding with sof → applies to that frame.
- **BYPASS/NOISE_ONLY**: BYPASS with noise_valid held 0 → rx=tx, rx_valid each beat, misalign=0. NOISE_ONLY, tx=500, n=-3 → rx=-3.
- **Misalignment**: in ADD, noise_valid arrives one cycle late → misalign=1, no rx_valid for that beat, flag persists across later good beats. stat_clr → 0.
- **Counter limits/reset**: CNT_W=4, 20 clipping beats → sat_cnt=15, smp_cnt=15. stat_clr on the same cycle as a clipping beat → 0. Assert rst_n low mid-frame → all outputs 0, no stale rx_valid after release.
